sqrt_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined sqrt_u32 instance between NREQ requesters. It arbitrates valid/ready requests and issues at most one operand per cycle into the sqrt pipeline. It tracks the requester ID of each in-flight operation in a tag delay line and returns each result on a shared response bus tagged with that ID. It sits between the requester cluster and the sqrt_u32 datapath.

---
 rtl/sqrt_pkg.sv | 15 +
 rtl/rr_arbiter_onehot.sv | 34 +++
 rtl/sqrt_rr_sched.sv | 123 ++++++++++++
 tb/tb_sqrt_rr_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants and the in-flight tag type for the sqrt_u32 datapath and its schedulers.
package sqrt_pkg;

    localparam int SQRT_XW      = 32;
    localparam int SQRT_YW      = 16;
    localparam int SQRT_LAT     = 16;
    // Widest requester ID any scheduler needs (NREQ <= 16); narrower users truncate.
    localparam int SQRT_IDW_MAX = 4;

    typedef struct packed {
        logic                    vld;
        logic [SQRT_IDW_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: grants the first requester found scanning ptr, ptr+1, ... mod N.
module rr_arbiter_onehot #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int            idx;
        logic [IW-1:0] idx_s;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            idx_s = IW'(idx);
            if (!gnt_any && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_rr_sched.sv
// Round-robin scheduler sharing one pipelined sqrt_u32 among NREQ requesters, with ID-tagged responses.
// Optional macro SQRT_RR_SCHED_CHK_EN adds a sticky err output for tag/counter consistency faults.
module sqrt_rr_sched
    import sqrt_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = SQRT_LAT,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(LAT + 3)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [NREQ*SQRT_XW-1:0] req_x,
    output logic [NREQ-1:0]         req_rdy,
    output logic                    sq_vld_in,
    output logic [SQRT_XW-1:0]      sq_x,
    input  logic                    sq_vld_out,
    input  logic [SQRT_YW-1:0]      sq_y,
    output logic                    rsp_vld,
    output logic [IDW-1:0]          rsp_id,
    output logic [SQRT_YW-1:0]      rsp_y,
    output logic                    busy,
    output logic [CW-1:0]           inflight
`ifdef SQRT_RR_SCHED_CHK_EN
    ,
    output logic                    err
`endif
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  sq_id;
    logic [NREQ-1:0] req_masked;
    logic            accept;
    tag_t            tag_line [LAT+1];
    tag_t            tail;

    assign req_masked = req_vld & {NREQ{en}};

    rr_arbiter_onehot #(.N(NREQ)) u_arb (
        .req     (req_masked),
        .ptr     (ptr),
        .gnt     (req_rdy),
        .gnt_idx (gnt_idx),
        .gnt_any (accept)
    );

    // Issue stage: registered operand, its owner, and the rotating priority pointer.
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_vld_in <= 1'b0;
            sq_x      <= '0;
            sq_id     <= '0;
            ptr       <= '0;
        end else begin
            sq_vld_in <= accept;
            if (accept) begin
                sq_x  <= req_x[gnt_idx*SQRT_XW +: SQRT_XW];
                sq_id <= gnt_idx;
                ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Fed from the issue register, so entry LAT lines up with sq_vld_out of the same op.
    // NOTE: the tag line is reset explicitly; stale valid bits would otherwise mislabel results after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) tag_line[k] <= '0;
        end else begin
            tag_line[0] <= '{vld: sq_vld_in, id: SQRT_IDW_MAX'(sq_id)};
            for (int k = 1; k <= LAT; k++) tag_line[k] <= tag_line[k-1];
        end
    end

    assign tail = tag_line[LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_y   <= '0;
        end else begin
            rsp_vld <= sq_vld_out;
            if (sq_vld_out) begin
                rsp_y <= sq_y;
                // A phantom result has no owner; keep the last ID rather than invent one.
                if (tail.vld) rsp_id <= IDW'(tail.id);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({accept, sq_vld_out})
                2'b10:   if (inflight != '1) inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

`ifdef SQRT_RR_SCHED_CHK_EN
    logic chk_hit;

    assign chk_hit = (sq_vld_out != tail.vld)
                   || (accept && !sq_vld_out && inflight == '1)
                   || (!accept && sq_vld_out && inflight == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (chk_hit) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sqrt_rr_sched.sv
// Scoreboard bench for sqrt_rr_sched with a behavioural sqrt_u32 pipeline of latency LAT.
module tb_sqrt_rr_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 16;
    localparam int IDW  = $clog2(NREQ);
    localparam int CW   = $clog2(LAT + 3);

    typedef struct {
        logic [31:0] x;
        int          y;
    } op_t;

    typedef struct {
        int id;
        int y;
        int cyc;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } gnt_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ-1:0]   req_rdy;
    logic              sq_vld_in;
    logic [31:0]       sq_x;
    logic              sq_vld_out;
    logic [15:0]       sq_y;
    logic              rsp_vld;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_y;
    logic              busy;
    logic [CW-1:0]     inflight;
`ifdef SQRT_RR_SCHED_CHK_EN
    logic              err;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     peak     = 0;
    logic   spur     = 1'b0;
    logic   spur_expect = 1'b0;
    int     cur_y [NREQ];
    op_t    drv_q [NREQ][$];
    exp_t   sb [$];
    gnt_t   gnt_log [$];

    sqrt_rr_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_vld    (req_vld),
        .req_x      (req_x),
        .req_rdy    (req_rdy),
        .sq_vld_in  (sq_vld_in),
        .sq_x       (sq_x),
        .sq_vld_out (sq_vld_out),
        .sq_y       (sq_y),
        .rsp_vld    (rsp_vld),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .busy       (busy),
        .inflight   (inflight)
`ifdef SQRT_RR_SCHED_CHK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        longint r = 0;
        longint t;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return 16'(r);
    endfunction

    // sqrt_u32 stand-in: vld_in sampled at edge e appears on vld_out after edge e+LAT.
    logic        pv [LAT+1];
    logic [15:0] py [LAT+1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                pv[k] <= 1'b0;
                py[k] <= '0;
            end
        end else begin
            pv[0] <= sq_vld_in;
            py[0] <= isqrt(sq_x);
            for (int k = 1; k <= LAT; k++) begin
                pv[k] <= pv[k-1];
                py[k] <= py[k-1];
            end
        end
    end
    assign sq_vld_out = pv[LAT] | spur;
    assign sq_y       = py[LAT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: present the head of each requester queue just after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (drv_q[i].size() != 0) begin
                    req_vld[i]        = 1'b1;
                    req_x[32*i +: 32] = drv_q[i][0].x;
                    cur_y[i]          = drv_q[i][0].y;
                end else begin
                    req_vld[i]        = 1'b0;
                    req_x[32*i +: 32] = '0;
                end
            end
        end
    end

    // Issue side: each completed handshake pushes its hand-computed result onto the scoreboard.
    always @(negedge clk) begin
        if (rst_n && req_rdy != '0) begin
            check("rdy_onehot_valid", 32'(($onehot(req_rdy) && ((req_rdy & ~req_vld) == '0))), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_rdy[i]) begin
                    sb.push_back('{id: i, y: cur_y[i], cyc: cyc});
                    gnt_log.push_back('{id: i, cyc: cyc});
                    if (drv_q[i].size() != 0) void'(drv_q[i].pop_front());
                end
            end
        end
    end

    // Monitor: pops and compares whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_vld) begin
            if (spur_expect) begin
                spur_expect = 1'b0;
            end else if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_y", 32'(rsp_y), 32'(e.y));
                check("rsp_latency", 32'(cyc - e.cyc), 32'(LAT + 3));
            end
        end
        if (rst_n && int'(inflight) > peak) peak = int'(inflight);
    end

    function automatic bit drv_empty();
        for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget, input bit incl_drv);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0 || (incl_drv && !drv_empty())) && n < budget);
        check(name, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_drained(input int i, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (drv_q[i].size() != 0 && n < budget);
        check("drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   stray;
        logic rdy_seen;
        int   exp_order [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

        rst_n   = 1'b0;
        en      = 1'b0;
        req_vld = '0;
        req_x   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy",   32'(req_rdy),   32'd0);
        check("rst_sq_vld_in", 32'(sq_vld_in), 32'd0);
        check("rst_sq_x",      sq_x,           32'd0);
        check("rst_rsp_vld",   32'(rsp_vld),   32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_y",     32'(rsp_y),     32'd0);
        check("rst_inflight",  32'(inflight),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        en    = 1'b1;

        // Single operation from requester 0.
        drv_q[0].push_back('{x: 32'd2147483648, y: 46340});
        wait_idle("s1_timeout", 200, 1'b1);
        check("s1_grants", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) check("s1_grant_id", 32'(gnt_log[0].id), 32'd0);
        check("s1_busy_after", 32'(busy), 32'd0);

        // Back-to-back from requester 1.
        gnt_log.delete();
        peak = 0;
        @(posedge clk);
        #2;
        drv_q[1].push_back('{x: 32'hFFFF_FFFF, y: 65535});
        drv_q[1].push_back('{x: 32'd0,         y: 0});
        drv_q[1].push_back('{x: 32'd1,         y: 1});
        drv_q[1].push_back('{x: 32'd100,       y: 10});
        wait_idle("s2_timeout", 200, 1'b1);
        check("s2_peak", 32'(peak), 32'd4);
        check("s2_grants", 32'(gnt_log.size()), 32'd4);
        for (int k = 0; k < gnt_log.size(); k++) begin
            check("s2_grant_id", 32'(gnt_log[k].id), 32'd1);
            if (k > 0) check("s2_grant_gap", 32'(gnt_log[k].cyc - gnt_log[k-1].cyc), 32'd1);
        end

        // All four requesters; pointer is at 2 after the last grant to requester 1.
        gnt_log.delete();
        @(posedge clk);
        #2;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                drv_q[i].push_back('{x: 32'(i * i + i), y: i});
        wait_idle("s3_timeout", 200, 1'b1);
        check("s3_grants", 32'(gnt_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            check("s3_grant_order", 32'(gnt_log[k].id), 32'(exp_order[k]));

        // Enable dropped with three ops in flight and requests pending.
        gnt_log.delete();
        @(posedge clk);
        #2;
        drv_q[2].push_back('{x: 32'd49, y: 7});
        drv_q[2].push_back('{x: 32'd64, y: 8});
        drv_q[2].push_back('{x: 32'd81, y: 9});
        wait_drained(2, 50);
        en = 1'b0;
        drv_q[0].push_back('{x: 32'd144, y: 12});
        drv_q[3].push_back('{x: 32'd169, y: 13});
        check("s4_inflight3", 32'(inflight), 32'd3);
        rdy_seen = 1'b0;
        for (int n = 0; n < LAT + 8; n++) begin
            @(negedge clk);
            rdy_seen = rdy_seen | (req_rdy != '0);
        end
        check("s4_rdy_while_en0", 32'(rdy_seen), 32'd0);
        check("s4_busy_drained", 32'(busy), 32'd0);
        check("s4_sb_drained", 32'(sb.size()), 32'd0);
        check("s4_grants_before", 32'(gnt_log.size()), 32'd3);
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_idle("s4_timeout", 200, 1'b1);
        check("s4_grants_total", 32'(gnt_log.size()), 32'd5);
        if (gnt_log.size() >= 5) begin
            check("s4_resume_first", 32'(gnt_log[3].id), 32'd3);
            check("s4_resume_second", 32'(gnt_log[4].id), 32'd0);
        end

        // Reset with five ops in flight.
        @(posedge clk);
        #2;
        for (int k = 2; k <= 6; k++) drv_q[1].push_back('{x: 32'(k * k), y: k});
        wait_drained(1, 50);
        check("s5_inflight5", 32'(inflight), 32'd5);
        rst_n = 1'b0;
        #1;
        check("s5_sq_vld_in", 32'(sq_vld_in), 32'd0);
        check("s5_sq_x",      sq_x,           32'd0);
        check("s5_rsp_vld",   32'(rsp_vld),   32'd0);
        check("s5_rsp_id",    32'(rsp_id),    32'd0);
        check("s5_rsp_y",     32'(rsp_y),     32'd0);
        check("s5_inflight",  32'(inflight),  32'd0);
        check("s5_busy",      32'(busy),      32'd0);
        sb.delete();
        gnt_log.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < LAT + 8; n++) begin
            @(negedge clk);
            if (rsp_vld) stray++;
        end
        check("s5_no_rsp_after_rst", 32'(stray), 32'd0);
        check("s5_inflight_after", 32'(inflight), 32'd0);
        @(posedge clk);
        #2;
        drv_q[3].push_back('{x: 32'd99, y: 9});
        wait_idle("s5_timeout", 200, 1'b1);
        check("s5_grants", 32'(gnt_log.size()), 32'd1);

`ifdef SQRT_RR_SCHED_CHK_EN
        check("s6_err_clean", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        spur_expect = 1'b1;
        spur        = 1'b1;
        @(posedge clk);
        #2;
        spur = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_err_set", 32'(err), 32'd1);
        repeat (10) @(negedge clk);
        check("s6_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_err_reset", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
